// File: rtl/game_timer_pkg.sv
// Shared types and defaults for the game clock and the game countdown.
package game_timer_pkg;
  localparam int unsigned GT_TICK_DIV = 1000000;
  localparam int unsigned GT_WIDTH    = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } gt_state_e;
endpackage

// File: rtl/game_countdown_tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled, strobes tick on the wrap.
module tick_prescaler
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = GT_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
  end

  assign tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_countdown.sv
// Down-counting game timer in tenths of a second with a one-cycle timeout strobe.
// Define GAME_COUNTDOWN_AUTO_RELOAD_EN to restart from the last preset on expiry.
module game_countdown
  import game_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = GT_WIDTH,
  parameter int unsigned TICK_DIV = GT_TICK_DIV
) (
  input  logic             CLOCK10M,
  input  logic             KEY0,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count_out,
  output logic             running,
  output logic             expired,
  output logic             timeout_pulse
);
  gt_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             running_q, expired_q, pulse_q, pulse_d;
  logic             pre_en, pre_clear, tick;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Prescaler freezes on the cycle a pause is accepted so no tick is lost.
  assign pre_clear = load || (state_q == ST_IDLE && start);
  assign pre_en    = (state_q == ST_RUN) && !load && !(pause && !start);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk    (CLOCK10M),
    .rst_n  (KEY0),
    .enable (pre_en),
    .clear  (pre_clear),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d = load_value;
      state_d = ST_IDLE;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          if (count_q == '0) begin
            state_d = ST_EXPIRED;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause && !start) begin
            state_d = ST_PAUSE;
          end else if (tick && count_q != '0) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              pulse_d = 1'b1;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != '0) count_d = reload_q;
              else                state_d = ST_EXPIRED;
`else
              state_d = ST_EXPIRED;
`endif
            end
          end
        end
        ST_PAUSE: if (start && !pause) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK10M) begin
    if (!KEY0) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
      pulse_q   <= pulse_d;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count_out     = count_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign timeout_pulse = pulse_q;
endmodule

// File: tb/tb_game_countdown.sv
// Bench for game_countdown: directed scenarios plus random stimulus against a cycle model.
module tb_game_countdown;
  localparam int W  = 10;
  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic         clk = 1'b0;
  logic         key0 = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [W-1:0] lv = '0;
  logic [W-1:0] count_out;
  logic         running, expired, timeout_pulse;

  game_countdown #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .CLOCK10M      (clk),
    .KEY0          (key0),
    .load          (load),
    .load_value    (lv),
    .start         (start),
    .pause         (pause),
    .count_out     (count_out),
    .running       (running),
    .expired       (expired),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: mode, remaining tenths, cycles of RUN since the last tick, last preset.
  int m_mode = M_IDLE, m_rem = 0, m_run_cyc = 0, m_preset = 0;
  bit m_pulse = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit ld, input int v, input bit st, input bit ps);
    m_pulse = 0;
    if (!r) begin
      m_mode = M_IDLE; m_rem = 0; m_run_cyc = 0; m_preset = 0;
    end else if (ld) begin
      m_rem = v; m_preset = v; m_run_cyc = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (st) begin
          if (m_rem == 0) begin m_mode = M_EXP; m_pulse = 1; end
          else begin m_mode = M_RUN; m_run_cyc = 0; end
        end
        M_RUN: begin
          if (ps && !st) m_mode = M_PAUSE;
          else begin
            m_run_cyc++;
            if (m_run_cyc == TD) begin
              m_run_cyc = 0;
              m_rem--;
              if (m_rem == 0) begin
                m_pulse = 1;
`ifdef GAME_COUNTDOWN_AUTO_RELOAD_EN
                if (m_preset != 0) m_rem = m_preset;
                else m_mode = M_EXP;
`else
                m_mode = M_EXP;
`endif
              end
            end
          end
        end
        M_PAUSE: if (st && !ps) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit ld, input int v, input bit st, input bit ps);
    key0 = r; load = ld; lv = v[W-1:0]; start = st; pause = ps;
    @(posedge clk);
    model(r, ld, v, st, ps);
    #1;
    chk("count", 32'(count_out), 32'(m_rem));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("expired", 32'(expired), 32'(m_mode == M_EXP));
    chk("pulse", 32'(timeout_pulse), 32'(m_pulse));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(count_out), 0);
    chk("rst_flags", {29'd0, running, expired, timeout_pulse}, 0);

    // Reset mid-RUN, then start with nothing loaded.
    step(1, 1, 5, 0, 0); step(1, 0, 0, 1, 0); idle(5);
    step(0, 0, 0, 0, 0);
    chk("midrun_rst_count", 32'(count_out), 0);
    chk("midrun_rst_run", 32'(running), 0);
    step(1, 0, 0, 1, 0);
    chk("empty_start_exp", 32'(expired), 1);
    chk("empty_start_pulse", 32'(timeout_pulse), 1);
    step(1, 0, 0, 0, 0);
    chk("empty_start_pulse_once", 32'(timeout_pulse), 0);

`ifndef GAME_COUNTDOWN_AUTO_RELOAD_EN
    // load 3, start: 2,1,0 at +4,+8,+12.
    step(1, 1, 3, 0, 0); step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 4)  chk("l3_c4", 32'(count_out), 2);
      if (i == 8)  chk("l3_c8", 32'(count_out), 1);
      if (i == 11) chk("l3_c11_pulse", 32'(timeout_pulse), 0);
      if (i == 12) begin
        chk("l3_c12", 32'(count_out), 0);
        chk("l3_c12_pulse", 32'(timeout_pulse), 1);
      end
    end
    step(1, 0, 0, 1, 0);
    chk("l3_start_ignored", 32'(expired), 1);
`else
    // Auto reload: load 2 -> 1, 0->2 with pulse, 1, ...
    step(1, 1, 2, 0, 0); step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, 0, 0, 0);
      if (i == 4)  chk("ar_c4", 32'(count_out), 1);
      if (i == 8) begin
        chk("ar_c8", 32'(count_out), 2);
        chk("ar_c8_pulse", 32'(timeout_pulse), 1);
      end
      if (i == 12) chk("ar_c12", 32'(count_out), 1);
      chk("ar_running", 32'(running), 1);
      chk("ar_expired", 32'(expired), 0);
    end
`endif

    // Pause and resume: no tick lost or gained.
    step(1, 1, 5, 0, 0); step(1, 0, 0, 1, 0); idle(6);
    step(1, 0, 0, 0, 1); idle(10);
    chk("pause_hold", 32'(count_out), 4);
    step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
    chk("resume_c1", 32'(count_out), 4);
    step(1, 0, 0, 0, 0);
    chk("resume_c2", 32'(count_out), 3);
    idle(14);

    // load beats start while running.
    step(1, 1, 9, 0, 0); step(1, 0, 0, 1, 0); idle(4 * 7);
    chk("pre_load_count", 32'(count_out), 2);
    step(1, 1, 7, 1, 0);
    chk("load_over_start", 32'(count_out), 7);
    chk("load_over_start_run", 32'(running), 0);
    step(1, 0, 0, 1, 0); idle(3);
    chk("reload_latency_c3", 32'(count_out), 7);
    step(1, 0, 0, 0, 0);
    chk("reload_latency_c4", 32'(count_out), 6);

    // start+pause together keeps running; then load 0 + start expires at once.
    step(1, 0, 0, 1, 1);
    chk("start_pause_run", 32'(running), 1);
    idle(6);
    step(1, 1, 0, 0, 0); step(1, 0, 0, 1, 0);
    chk("zero_start_exp", 32'(expired), 1);
    chk("zero_start_pulse", 32'(timeout_pulse), 1);
    step(1, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, st, ps;
      r  = ($urandom_range(199) != 0);
      ld = ($urandom_range(19) == 0);
      st = ($urandom_range(5) == 0);
      ps = ($urandom_range(9) == 0);
      step(r, ld, int'($urandom_range(12)), st, ps);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_countdown.md
Name: game_countdown

Overview:
- Down-counting companion to the up-counting game clock. Loads a preset in tenths of a second, counts down one unit per tick, and flags expiry.
- Sits between the KEY/switch input logic and the game-control/display logic. It drives the remaining-time value and a single-cycle timeout event.
- One clock domain: CLOCK10M.

Parameters:
- WIDTH, 10, bit width of the preset and count value.
- TICK_DIV, 1000000, number of CLOCK10M cycles per count unit (0.1 s at 10 MHz). Benches override it to a small value; legal range is at least 2.

Ports:
- CLOCK10M  input  1  system clock, 10 MHz.
- KEY0  input  1  reset: synchronous, active-low.
- load  input  1  one-cycle request to load load_value.
- load_value  input  WIDTH  preset in tenths of a second.
- start  input  1  start or resume the countdown.
- pause  input  1  freeze the countdown.
- count_out  output  WIDTH  remaining time.
- running  output  1  high while in state RUN.
- expired  output  1  high while in state EXPIRED.
- timeout_pulse  output  1  one-cycle strobe when the count reaches 0.

Behaviour:
- Reset (KEY0==0 sampled on a CLOCK10M rising edge):
  - state=IDLE; count_out=0; prescaler=0; reload register=0.
  - running=0; expired=0; timeout_pulse=0.
  - Reset has priority over every other input.
- States: IDLE, RUN, PAUSE, EXPIRED. running and expired are registered decodes of the state.
- Input priority per cycle: reset > load > start/pause.
- load, from any state:
  - count_out<=load_value; reload register<=load_value; prescaler<=0; state<=IDLE.
  - start or pause in the same cycle is ignored.
- IDLE:
  - start with count_out!=0 -> RUN, prescaler<=0.
  - start with count_out==0 -> EXPIRED, with timeout_pulse=1 for one cycle.
  - pause is ignored.
- RUN:
  - prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler<=0 and count_out<=count_out-1.
  - If that decrement produces 0: state<=EXPIRED and timeout_pulse=1 on the same edge.
  - First decrement lands exactly TICK_DIV cycles after the edge that accepted start.
  - pause -> PAUSE; prescaler and count_out hold.
- PAUSE:
  - start -> RUN; the prescaler resumes from its held value, so no tick is lost or gained.
  - pause is ignored.
- start and pause asserted together in RUN or PAUSE: no state change.
- EXPIRED:
  - count_out holds 0; expired=1; start and pause are ignored.
  - Only load or reset leaves this state.
- Arithmetic:
  - Unsigned WIDTH bits; count_out never wraps below 0.
  - Prescaler width is ceil(log2(TICK_DIV)) bits.
- Level inputs: start, pause and load are level-sampled each cycle. A held start in RUN has no effect. Callers deliver pulses.

Optional Feature:
- Macro: GAME_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On the decrement to 0, count_out<=reload register and the block stays in RUN.
  - timeout_pulse still fires for one cycle; expired stays 0.
  - If the reload register is 0, behaviour is the same as without the macro.
- Undefined: the block enters EXPIRED as described above and the reload register is unused (may be optimised away).

Decomposition:
- Package game_timer_pkg:
  - State enum (IDLE, RUN, PAUSE, EXPIRED).
  - Default TICK_DIV constant (1000000) and default WIDTH (10), shared with the game clock.
- Sub-module tick_prescaler:
  - Ports: enable, clear, tick.
  - Counts 0..TICK_DIV-1 while enabled and holds while disabled.
  - Drives tick for one cycle at terminal count.

Test Plan (TICK_DIV=4, WIDTH=10):
- Reset mid-RUN (KEY0 low for one edge) -> next cycle count_out=0, state IDLE, all flags 0. A later start with no load goes straight to EXPIRED with one timeout_pulse.
- load 3, then start -> count_out goes 2, 1, 0 at cycles 4, 8, 12 after start. timeout_pulse is high only at cycle 12; expired=1 from then on; a start afterwards is ignored.
- load 5, start, pause at cycle 6 (count 4, prescaler 2), hold 10 cycles, start -> count_out stays 4 while paused. Next decrement occurs 2 cycles after resume; counting continues to 0.
- Same cycle load 7 and start while in RUN at count 2 -> count_out=7, state IDLE, no decrement; a start next cycle resumes with the full TICK_DIV latency.
- Simultaneous start and pause in RUN -> no state change and the count continues. load 0 then start -> EXPIRED next edge with a single timeout_pulse.
- With GAME_COUNTDOWN_AUTO_RELOAD_EN, load 2, start -> sequence 1, 0→2 (timeout_pulse), 1, 2... every 4 cycles; running stays 1 and expired never asserts.
